// File: rtl/uart_pkg.sv
// Shared definitions for the uart MMIO controller: register offsets, the
// CTRL register layout, the controller FSM state type and the RX-empty sentinel.
package uart_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CTRL_W   = 15;
  localparam int unsigned STATUS_W = 4;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned OFS_W    = 3;
  localparam int unsigned IEN_W    = 3;
  localparam int unsigned BAUD_W   = 12;

  // Register offsets, decoded from addr[4:2]
  localparam logic [OFS_W-1:0] CTRL_OFS   = 3'd0;
  localparam logic [OFS_W-1:0] STATUS_OFS = 3'd1;
  localparam logic [OFS_W-1:0] TXDATA_OFS = 3'd2;
  localparam logic [OFS_W-1:0] RXDATA_OFS = 3'd3;
  localparam logic [OFS_W-1:0] IEN_OFS    = 3'd4;

  // uart_status bit positions: {txff, txfe, rxff, rxfe}
  localparam int unsigned ST_RXFE = 0;
  localparam int unsigned ST_RXFF = 1;
  localparam int unsigned ST_TXFE = 2;
  localparam int unsigned ST_TXFF = 3;

  // IEN bit positions: {ovf_en, txe_en, rxne_en}
  localparam int unsigned IEN_RXNE = 0;
  localparam int unsigned IEN_TXE  = 1;
  localparam int unsigned IEN_OVF  = 2;

  // STATUS store bit that clears the overflow flag
  localparam int unsigned OVF_CLR_BIT = 4;

  // Load value for RXDATA when the RX FIFO is empty (bit 8 = empty flag)
  localparam logic [DATA_W-1:0] RX_EMPTY_RDATA = 32'h0000_0100;

  typedef struct packed {
    logic              loopback;
    logic              two_stop;
    logic              parity_sel;
    logic [BAUD_W-1:0] baud_div;
  } uart_ctrl_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_WAIT = 3'd1,
    ST_RX_POP  = 3'd2,
    ST_RX_CAP  = 3'd3,
    ST_RESP    = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped controller between the LSU data port and the uart block.
// Holds CTRL/IEN, tracks TX overflow, sequences TX pushes and RX pops, and
// raises a registered level interrupt. One req/ack handshake per access.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   lsu_req/we/addr/wdata      LSU access request (held until lsu_ack)
//   lsu_rdata, lsu_ack         load data and one-cycle completion pulse
//   irq                        registered level interrupt
//   uart_control               {loopback, two_stop, parity_sel, baud_div}
//   tx_fifo_wr/tx_fifo_data_in TX FIFO push strobe and data
//   rx_fifo_rd/rx_fifo_data_out RX FIFO pop strobe and data (next cycle)
//   uart_status                {txff, txfe, rxff, rxfe}
module uart_mmio_ctrl
  import uart_pkg::*;
#(
  parameter logic [14:0] DEFAULT_CTRL = 15'h01B2,
  parameter int unsigned TX_WAIT_MAX  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_ack,
  output logic                irq,
  output logic [CTRL_W-1:0]   uart_control,
  output logic                tx_fifo_wr,
  output logic [BYTE_W-1:0]   tx_fifo_data_in,
  output logic                rx_fifo_rd,
  input  logic [BYTE_W-1:0]   rx_fifo_data_out,
  input  logic [STATUS_W-1:0] uart_status
);

  localparam int unsigned CNT_W = $clog2(TX_WAIT_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_WAIT_MAX - 1);

  ctrl_state_e        state_q, state_d;
  uart_ctrl_t         ctrl_q, ctrl_d;
  logic [IEN_W-1:0]   ien_q, ien_d;
  logic               ovf_q, ovf_d, ovf_set, ovf_clr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [OFS_W-1:0]   ofs_q;
  logic [CTRL_W-1:0]  wdata_q;
  logic               ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               tx_wr_q, tx_wr_d;
  logic               rx_rd_q, rx_rd_d;
  logic               irq_q, irq_d;
  logic               accept;
  logic [OFS_W-1:0]   req_ofs;
  logic               unused_bits;

  assign req_ofs     = lsu_addr[4:2];
  assign unused_bits = ^{lsu_addr[1:0], lsu_wdata[DATA_W-1:CTRL_W]};

  // Next-state, register-update and strobe logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ien_d   = ien_q;
    ovf_d   = ovf_q;
    ovf_set = 1'b0;
    ovf_clr = 1'b0;
    ack_d   = 1'b0;
    rdata_d = '0;
    tx_wr_d = 1'b0;
    rx_rd_d = 1'b0;
    accept  = 1'b0;
    irq_d   = (ien_q[IEN_RXNE] & ~uart_status[ST_RXFE]) |
              (ien_q[IEN_TXE]  &  uart_status[ST_TXFE]) |
              (ien_q[IEN_OVF]  &  ovf_q);

    unique case (state_q)
      ST_IDLE: begin
        if (lsu_req && !ack_q) begin
          accept = 1'b1;
          if (lsu_we && (req_ofs == TXDATA_OFS)) begin
            if (uart_status[ST_TXFF]) begin
              state_d = ST_TX_WAIT;
              cnt_d   = '0;
            end else begin
              state_d = ST_RESP;
              ack_d   = 1'b1;
              tx_wr_d = 1'b1;
            end
          end else if (!lsu_we && (req_ofs == RXDATA_OFS)) begin
            if (uart_status[ST_RXFE]) begin
              state_d = ST_RESP;
              ack_d   = 1'b1;
              rdata_d = RX_EMPTY_RDATA;
            end else begin
              state_d = ST_RX_POP;
              rx_rd_d = 1'b1;
            end
          end else begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            if (!lsu_we) begin
              unique case (req_ofs)
                CTRL_OFS:   rdata_d = DATA_W'(ctrl_q);
                STATUS_OFS: rdata_d = DATA_W'({ovf_q, uart_status});
                IEN_OFS:    rdata_d = DATA_W'(ien_q);
                default:    rdata_d = '0;
              endcase
            end
          end
        end
      end

      // Stall on a full TX FIFO; drop the write and flag overflow on timeout
      ST_TX_WAIT: begin
        if (!uart_status[ST_TXFF]) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          tx_wr_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          ovf_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RX_POP: begin
        state_d = ST_RX_CAP;
      end

      // Pop data is valid the cycle after the pop strobe
      ST_RX_CAP: begin
        state_d = ST_RESP;
        ack_d   = 1'b1;
        rdata_d = DATA_W'(rx_fifo_data_out);
      end

      // Stores commit as the ack cycle ends, so they are visible the cycle after ack
      ST_RESP: begin
        state_d = ST_IDLE;
        if (we_q) begin
          unique case (ofs_q)
            CTRL_OFS:   ctrl_d  = uart_ctrl_t'(wdata_q);
            IEN_OFS:    ien_d   = wdata_q[IEN_W-1:0];
            STATUS_OFS: ovf_clr = wdata_q[OVF_CLR_BIT];
            default:    ;
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Overflow set takes priority over a simultaneous clear
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ctrl_q  <= uart_ctrl_t'(DEFAULT_CTRL);
      ien_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ofs_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      tx_wr_q <= 1'b0;
      rx_rd_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      ien_q   <= ien_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      tx_wr_q <= tx_wr_d;
      rx_rd_q <= rx_rd_d;
      irq_q   <= irq_d;
      if (accept) begin
        we_q    <= lsu_we;
        ofs_q   <= req_ofs;
        wdata_q <= lsu_wdata[CTRL_W-1:0];
      end
    end
  end

  assign lsu_ack         = ack_q;
  assign lsu_rdata       = rdata_q;
  assign irq             = irq_q;
  assign uart_control    = ctrl_q;
  assign tx_fifo_wr      = tx_wr_q;
  assign tx_fifo_data_in = wdata_q[BYTE_W-1:0];
  assign rx_fifo_rd      = rx_rd_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: a directed vector table, hand-written
// multi-cycle sequences (timeout, interrupt, reset mid-access) and randomized
// accesses checked against a register-level model of the controller.
module tb_uart_mmio_ctrl;

  localparam logic [14:0] DEF_CTRL = 15'h01B2;
  localparam int          TMAX     = 1024;

  logic        clk;
  logic        reset;
  logic        lsu_req;
  logic        lsu_we;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_ack;
  logic        irq;
  logic [14:0] uart_control;
  logic        tx_fifo_wr;
  logic [7:0]  tx_fifo_data_in;
  logic        rx_fifo_rd;
  logic [7:0]  rx_fifo_data_out;
  logic [3:0]  uart_status;

  // Environment: status bits, RX FIFO contents
  logic       txff_v, txfe_v, rxff_v, rxfe_v;
  logic [7:0] rx_q[$];

  // Register-level model
  logic [14:0] m_ctrl;
  logic [2:0]  m_ien;
  logic        m_ovf;

  int n_total;
  int n_pass;

  always_comb uart_status = {txff_v, txfe_v, rxff_v, rxfe_v};

  uart_mmio_ctrl #(.DEFAULT_CTRL(DEF_CTRL), .TX_WAIT_MAX(TMAX)) dut (
    .clk              (clk),
    .reset            (reset),
    .lsu_req          (lsu_req),
    .lsu_we           (lsu_we),
    .lsu_addr         (lsu_addr),
    .lsu_wdata        (lsu_wdata),
    .lsu_rdata        (lsu_rdata),
    .lsu_ack          (lsu_ack),
    .irq              (irq),
    .uart_control     (uart_control),
    .tx_fifo_wr       (tx_fifo_wr),
    .tx_fifo_data_in  (tx_fifo_data_in),
    .rx_fifo_rd       (rx_fifo_rd),
    .rx_fifo_data_out (rx_fifo_data_out),
    .uart_status      (uart_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          hold;
    logic        rx_fill;
    logic [7:0]  rx_byte;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_tx;
    int          exp_rx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic model_irq();
    return (m_ien[0] & ~rxfe_v) | (m_ien[1] & txfe_v) | (m_ien[2] & m_ovf);
  endfunction

  function automatic vec_t mk(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                              input int hold, input logic rx_fill, input logic [7:0] rx_byte,
                              input logic [31:0] exp_rdata, input int exp_lat,
                              input int exp_tx, input int exp_rx);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.hold = hold;
    v.rx_fill = rx_fill; v.rx_byte = rx_byte; v.exp_rdata = exp_rdata;
    v.exp_lat = exp_lat; v.exp_tx = exp_tx; v.exp_rx = exp_rx;
    return v;
  endfunction

  task automatic model_reset();
    m_ctrl = DEF_CTRL;
    m_ien  = 3'b000;
    m_ovf  = 1'b0;
  endtask

  // Expected outcome of one access from the register map, and the model update it causes
  task automatic predict(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                         input int hold, output logic [31:0] exp_rd, output int exp_lat,
                         output int exp_tx, output int exp_rx);
    logic [3:0] st;
    st      = {(hold > 0), txfe_v, rxff_v, rxfe_v};
    exp_rd  = 32'h0;
    exp_lat = 1;
    exp_tx  = 0;
    exp_rx  = 0;
    case (addr[4:2])
      3'd0: if (we) m_ctrl = wdata[14:0]; else exp_rd = {17'h0, m_ctrl};
      3'd1: if (we) begin if (wdata[4]) m_ovf = 1'b0; end
            else exp_rd = {27'h0, m_ovf, st};
      3'd2: if (we) begin exp_tx = 1; exp_lat = hold + 1; end
      3'd3: if (!we) begin
              if (rx_q.size() == 0) exp_rd = 32'h100;
              else begin exp_rd = {24'h0, rx_q[0]}; exp_lat = 3; exp_rx = 1; end
            end
      3'd4: if (we) m_ien = wdata[2:0]; else exp_rd = {29'h0, m_ien};
      default: ;
    endcase
  endtask

  // One access; called just after a rising edge. txff is high for cycles 0..hold-1.
  task automatic access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata, output int lat,
                        output int ntx, output int nrx, output logic [7:0] txd, output int extra);
    bit done;
    lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
    txff_v = (hold > 0);
    rdata = 32'h0; lat = -1; ntx = 0; nrx = 0; txd = 8'h0; extra = 0; done = 1'b0;
    for (int k = 1; k <= 2000 && !done; k++) begin
      @(posedge clk); #1;
      txff_v = (k < hold);
      if (tx_fifo_wr) begin ntx++; txd = tx_fifo_data_in; end
      if (rx_fifo_rd) begin
        nrx++;
        if (rx_q.size() > 0) rx_fifo_data_out = rx_q.pop_front();
        rxfe_v = (rx_q.size() == 0);
      end
      if (tx_fifo_wr && rx_fifo_rd) extra++;
      if (lsu_ack) begin done = 1'b1; lat = k; rdata = lsu_rdata; end
    end
    lsu_req = 1'b0;
    txff_v  = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (tx_fifo_wr || rx_fifo_rd || lsu_ack) extra++;
    end
  endtask

  task automatic run_one(input string name, input logic we, input logic [4:0] addr,
                         input logic [31:0] wdata, input int hold, input logic [31:0] exp_rd,
                         input int exp_lat, input int exp_tx, input int exp_rx);
    logic [31:0] rd; int lat, ntx, nrx, extra; logic [7:0] txd;
    access(we, addr, wdata, hold, rd, lat, ntx, nrx, txd, extra);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " tx pulses"}, 32'(ntx), 32'(exp_tx));
    chk({name, " rx pulses"}, 32'(nrx), 32'(exp_rx));
    chk({name, " stray strobes"}, 32'(extra), 32'h0);
    if (!we) chk({name, " rdata"}, rd, exp_rd);
    if (exp_tx != 0) chk({name, " tx data"}, 32'(txd), 32'(wdata[7:0]));
    chk({name, " uart_control"}, 32'(uart_control), 32'(m_ctrl));
    chk({name, " irq"}, 32'(irq), 32'(model_irq()));
  endtask

  task automatic run_pred(input string name, input logic we, input logic [4:0] addr,
                          input logic [31:0] wdata, input int hold);
    logic [31:0] e_rd; int e_lat, e_tx, e_rx;
    predict(we, addr, wdata, hold, e_rd, e_lat, e_tx, e_rx);
    run_one(name, we, addr, wdata, hold, e_rd, e_lat, e_tx, e_rx);
  endtask

  vec_t tbl[14];

  initial begin
    logic [31:0] rd, d_rd; int lat, ntx, nrx, extra, d_lat, d_tx, d_rx; logic [7:0] txd;
    int vis;

    n_total = 0; n_pass = 0;
    reset = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    rx_fifo_data_out = '0; txff_v = 1'b0; txfe_v = 1'b1; rxff_v = 1'b0; rxfe_v = 1'b1;
    model_reset();

    tbl[0]  = mk(1'b0, 5'h00, 32'h0,          0,  1'b0, 8'h00, 32'h0000_01B2, 1,  0, 0);
    tbl[1]  = mk(1'b1, 5'h08, 32'h0000_005A,  0,  1'b0, 8'h00, 32'h0,         1,  1, 0);
    tbl[2]  = mk(1'b1, 5'h08, 32'hFFFF_FFA5,  10, 1'b0, 8'h00, 32'h0,         11, 1, 0);
    tbl[3]  = mk(1'b0, 5'h0C, 32'h0,          0,  1'b0, 8'h00, 32'h0000_0100, 1,  0, 0);
    tbl[4]  = mk(1'b0, 5'h0D, 32'h0,          0,  1'b1, 8'hC3, 32'h0000_00C3, 3,  0, 1);
    tbl[5]  = mk(1'b1, 5'h00, 32'hFFFF_4ABC,  0,  1'b0, 8'h00, 32'h0,         1,  0, 0);
    tbl[6]  = mk(1'b0, 5'h03, 32'h0,          0,  1'b0, 8'h00, 32'h0000_4ABC, 1,  0, 0);
    tbl[7]  = mk(1'b1, 5'h10, 32'hFFFF_FFF2,  0,  1'b0, 8'h00, 32'h0,         1,  0, 0);
    tbl[8]  = mk(1'b0, 5'h10, 32'h0,          0,  1'b0, 8'h00, 32'h0000_0002, 1,  0, 0);
    tbl[9]  = mk(1'b0, 5'h14, 32'h0,          0,  1'b0, 8'h00, 32'h0,         1,  0, 0);
    tbl[10] = mk(1'b1, 5'h1C, 32'hFFFF_FFFF,  0,  1'b0, 8'h00, 32'h0,         1,  0, 0);
    tbl[11] = mk(1'b0, 5'h08, 32'h0,          0,  1'b0, 8'h00, 32'h0,         1,  0, 0);
    tbl[12] = mk(1'b0, 5'h04, 32'h0,          0,  1'b0, 8'h00, 32'h0000_0005, 1,  0, 0);
    tbl[13] = mk(1'b1, 5'h04, 32'h0000_0010,  0,  1'b0, 8'h00, 32'h0,         1,  0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset ack", 32'(lsu_ack), 32'h0);
    chk("reset rdata", lsu_rdata, 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    chk("reset strobes", 32'({tx_fifo_wr, rx_fifo_rd}), 32'h0);
    chk("reset uart_control", 32'(uart_control), 32'(DEF_CTRL));
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rx_fill) begin rx_q.push_back(tbl[i].rx_byte); rxfe_v = 1'b0; end
      predict(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, d_rd, d_lat, d_tx, d_rx);
      run_one($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
              tbl[i].exp_rdata, tbl[i].exp_lat, tbl[i].exp_tx, tbl[i].exp_rx);
    end

    // TXDATA store against a permanently full FIFO: timeout, no push, overflow flagged
    access(1'b1, 5'h08, 32'h0000_0077, 1 << 20, rd, lat, ntx, nrx, txd, extra);
    chk("timeout latency in window", 32'(lat >= TMAX && lat <= TMAX + 1), 32'h1);
    chk("timeout tx pulses", 32'(ntx), 32'h0);
    chk("timeout stray strobes", 32'(extra), 32'h0);
    m_ovf = 1'b1;
    run_pred("status after timeout", 1'b0, 5'h04, 32'h0, 0);
    run_pred("ien ovf", 1'b1, 5'h10, 32'h4, 0);
    run_pred("status clear ovf", 1'b1, 5'h04, 32'h0000_0010, 0);
    run_pred("status after clear", 1'b0, 5'h04, 32'h0, 0);

    // RX-not-empty interrupt follows rxfe one cycle later
    run_pred("ien rxne", 1'b1, 5'h10, 32'h1, 0);
    rx_q.push_back(8'h3C); rxfe_v = 1'b0;
    chk("irq before rxfe seen", 32'(irq), 32'h0);
    @(posedge clk); #1;
    chk("irq one cycle after rxfe falls", 32'(irq), 32'h1);
    run_pred("pop to empty", 1'b0, 5'h0C, 32'h0, 0);

    // Reset while stalled in TX_WAIT
    run_pred("ctrl nondefault", 1'b1, 5'h00, 32'h0000_1234, 0);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 5'h08; lsu_wdata = 32'h99; txff_v = 1'b1;
    vis = 0;
    repeat (5) begin @(posedge clk); #1; if (lsu_ack || tx_fifo_wr || rx_fifo_rd) vis++; end
    chk("tx_wait no ack yet", 32'(vis), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; lsu_req = 1'b0; txff_v = 1'b0;
    model_reset();
    chk("rst tx_wait ack", 32'(lsu_ack), 32'h0);
    chk("rst tx_wait strobes", 32'({tx_fifo_wr, rx_fifo_rd}), 32'h0);
    chk("rst tx_wait uart_control", 32'(uart_control), 32'(DEF_CTRL));
    vis = 0;
    repeat (3) begin @(posedge clk); #1; if (lsu_ack || tx_fifo_wr || rx_fifo_rd) vis++; end
    chk("rst tx_wait stays quiet", 32'(vis), 32'h0);

    // Reset while in RX_POP
    rx_q.push_back(8'h81); rxfe_v = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 5'h0C;
    @(posedge clk); #1;
    chk("rx_pop strobe", 32'(rx_fifo_rd), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; lsu_req = 1'b0;
    rx_q.delete(); rxfe_v = 1'b1;
    chk("rst rx_pop ack", 32'(lsu_ack), 32'h0);
    chk("rst rx_pop strobes", 32'({tx_fifo_wr, rx_fifo_rd}), 32'h0);
    chk("rst rx_pop uart_control", 32'(uart_control), 32'(DEF_CTRL));
    vis = 0;
    repeat (3) begin @(posedge clk); #1; if (lsu_ack || tx_fifo_wr || rx_fifo_rd) vis++; end
    chk("rst rx_pop stays quiet", 32'(vis), 32'h0);
    run_pred("ctrl after reset", 1'b0, 5'h00, 32'h0, 0);

    // Randomized accesses against the model
    for (int i = 0; i < 150; i++) begin
      logic        r_we;
      logic [4:0]  r_addr;
      logic [31:0] r_wdata;
      int          r_hold;
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      r_wdata = $urandom;
      r_hold  = (r_we && r_addr[4:2] == 3'd2) ? int'($urandom_range(0, 4)) : 0;
      txfe_v  = 1'($urandom_range(0, 1));
      rxff_v  = 1'($urandom_range(0, 1));
      if (rx_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        rx_q.push_back(8'($urandom));
        rxfe_v = 1'b0;
      end
      run_pred($sformatf("rand%0d", i), r_we, r_addr, r_wdata, r_hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
